ebus_arbiter: RTL and testbench
===============================

// Module: ebus_arbiter
// PURPOSE
//  Parametrised, registered EBUS source arbiter and mux for the top level.
//  Selects one of NSRC drivers per eboxClk using fixed priority or round-robin
//  with ownership parking. Flags multi-driver conflicts and holds EBUS when idle.
//  Successor to the hard-coded 3-way EDP/IR/SCD if/else EBUS mux. Also serves RH20/DTE20.
// PARAMETERS
//  NSRC   8   number of EBUS sources (2..16); index 0 = highest fixed priority
//  WIDTH  36  EBUS data width, bit 0 = MSB
//  GW     4   width of grantIdx, >= clog2(NSRC)
// PORTS
//  eboxClk          in   1           EBOX clock, all state on posedge
//  eboxResetN       in   1           async reset, active low
//  rrMode           in   1           0 = fixed priority, 1 = round-robin with parking
//  drvReq           in   NSRC        per-source "XXXdrivingEBUS"
//  drvData          in   NSRC*WIDTH  source i data at [i*WIDTH +: WIDTH]
//  clrConflict      in   1           clears sticky conflict state
//  EBUS             out  WIDTH       registered bus, [0:WIDTH-1]
//  ebusValid        out  1           EBUS loaded from a source at last edge
//  grantOH          out  NSRC        one-hot winner of last edge, 0 if idle
//  grantIdx         out  GW          index of last winner, holds when idle
//  conflict         out  1           1-cycle pulse: >=2 drvReq bits at last edge
//  conflictSticky   out  1           set by conflict, cleared by clrConflict
//  conflictCount    out  16          saturating conflict count (optional feature)
//  firstConflict    out  NSRC        drvReq mask of first conflict since clear (opt.)
// BEHAVIOUR
//  - Reset (async, eboxResetN=0): EBUS=0, ebusValid=0, grantOH=0, grantIdx=0,
//    conflict=0, conflictSticky=0, conflictCount=0, firstConflict=0, rrPtr=NSRC-1.
//  - Latency 1: drvReq/drvData sampled at edge n; EBUS/grant outputs valid after edge n.
//  - Idle (drvReq==0): EBUS and grantIdx hold; ebusValid=0; grantOH=0.
//  - Fixed priority (rrMode=0): lowest asserted index wins each cycle; no parking.
//  - Round-robin (rrMode=1), two-state owner FSM IDLE/OWNED:
//    - OWNED and drvReq[owner]=1: owner keeps grant (parking, no preemption).
//    - Otherwise: winner is first asserted index scanning rrPtr+1 .. rrPtr, wrapping mod NSRC.
//      rrPtr <= winner; state OWNED.
//    - No request: state IDLE; rrPtr holds.
//  - rrMode change takes effect at the next edge.
//    - Changing to rrMode=0 drops ownership (FSM -> IDLE).
//    - rrPtr is never reset by a mode change.
//  - Conflict = popcount(drvReq)>=2 at an edge, in either mode. Registered with the grant.
//    - A grant is still made; conflict is diagnostic only.
//  - conflictSticky: set on conflict.
//    - Cleared on clrConflict when no conflict that cycle.
//    - Conflict and clrConflict in the same cycle: set wins.
//  - drvReq bits at index >= NSRC do not exist; grantIdx upper bits are 0.
// CONFIGURATION
//  EBUS_CONFLICT_LOG_EN defined:
//    - conflictCount increments per conflict and saturates at 16'hFFFF.
//    - firstConflict captures drvReq on the first conflict while conflictSticky=0.
//    - clrConflict zeroes both, but loses to a same-cycle conflict:
//      count becomes 1 and the mask is recaptured.
//  EBUS_CONFLICT_LOG_EN undefined:
//    - Both ports remain and are tied 0.
//    - No counter or mask registers are built.
// TESTING (NSRC=8, WIDTH=36)
//  1. Reset: hold eboxResetN=0 mid-traffic -> all outputs 0 immediately; first
//     drvReq=8'h01, data0=36'o123456701234 -> EBUS=36'o123456701234, grantIdx=0.
//  2. Priority: rrMode=0, drvReq=8'h28 -> grantIdx=3, grantOH=8'h08, conflict=1,
//     conflictSticky=1; next cycle drvReq=0 -> EBUS holds, ebusValid=0.
//  3. Round-robin: rrMode=1, drvReq=8'h81 pulsed 1 cycle at a time (each pulse
//     followed by an idle cycle) -> grants 0,7,0,7.
//  4. Parking: drvReq=8'h81 continuously -> grant 0 for all cycles while bit 0 set;
//     drop bit 0 -> grant 7 the next cycle.
//  5. Sticky/clear: conflict and clrConflict the same cycle -> sticky stays 1;
//     clrConflict alone -> 0.
//  6. EBUS_CONFLICT_LOG_EN: 3 conflicts -> conflictCount=3,
//     firstConflict=first mask; force 70000 -> 16'hFFFF. Undefined -> both 0 always.

Source files
------------

// File: rtl/ebus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ebus_arbiter                                                    |
// | Purpose  : Registered EBUS source arbiter and data mux. Picks one of NSRC  |
// |            drivers per eboxClk edge by fixed priority (index 0 highest)    |
// |            or by round-robin with ownership parking. Flags multi-driver    |
// |            conflicts and holds EBUS while no source drives.                |
// | Ports    : eboxClk, eboxResetN (async, active low)                         |
// |            rrMode        0 = fixed priority, 1 = round-robin with parking  |
// |            drvReq/drvData per-source request and data (source i at        |
// |                          drvData[i*WIDTH +: WIDTH])                        |
// |            clrConflict   clears sticky conflict state                      |
// |            EBUS/ebusValid/grantOH/grantIdx   registered grant results      |
// |            conflict/conflictSticky           conflict diagnostics          |
// |            conflictCount/firstConflict       conflict log (optional)       |
// | Config   : EBUS_CONFLICT_LOG_EN builds the saturating conflict counter and |
// |            the first-conflict mask; otherwise both ports are tied to 0.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ebus_arbiter #(
   parameter int NSRC  = 8,
   parameter int WIDTH = 36,
   parameter int GW    = 4
) (
   input  logic                  eboxClk,
   input  logic                  eboxResetN,
   input  logic                  rrMode,
   input  logic [NSRC-1:0]       drvReq,
   input  logic [NSRC*WIDTH-1:0] drvData,
   input  logic                  clrConflict,
   output logic [0:WIDTH-1]      EBUS,
   output logic                  ebusValid,
   output logic [NSRC-1:0]       grantOH,
   output logic [GW-1:0]         grantIdx,
   output logic                  conflict,
   output logic                  conflictSticky,
   output logic [15:0]           conflictCount,
   output logic [NSRC-1:0]       firstConflict
);

   localparam logic [GW-1:0] LAST_IDX = GW'(NSRC-1);

   typedef enum logic {
      OWN_IDLE  = 1'b0,
      OWN_OWNED = 1'b1
   } own_state_t;

   own_state_t        state, state_nxt;
   logic [GW-1:0]     rr_ptr, rr_ptr_nxt;

   logic              any_req;
   logic              multi_req;
   logic              req_at_ptr;
   logic [GW-1:0]     fixed_idx;
   logic [GW-1:0]     scan_start;
   logic [2*NSRC-1:0] req_shift;
   logic [GW-1:0]     rot_off;
   logic [GW:0]       rr_sum;
   logic [GW-1:0]     rr_idx;
   logic [GW-1:0]     win_idx;
   logic [NSRC-1:0]   win_oh;
   logic [WIDTH-1:0]  sel_data;

   assign any_req    = |drvReq;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_req  = |(drvReq & (drvReq - NSRC'(1)));
   // The current owner is always the last round-robin winner, held in rr_ptr.
   assign req_at_ptr = |(drvReq & (NSRC'(1) << rr_ptr));

   // Fixed priority: lowest asserted index.
   always_comb begin
      fixed_idx = '0;
      for (int i = NSRC-1; i >= 0; i--) begin
         if (drvReq[i]) fixed_idx = GW'(i);
      end
   end

   // Round-robin scan starting just after rr_ptr. Rotating a doubled copy of
   // the request vector lets a plain lowest-bit search do the wrapping scan.
   always_comb begin
      scan_start = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + GW'(1);
      req_shift  = {drvReq, drvReq} >> scan_start;
      rot_off    = '0;
      for (int i = NSRC-1; i >= 0; i--) begin
         if (req_shift[i]) rot_off = GW'(i);
      end
      rr_sum = {1'b0, scan_start} + {1'b0, rot_off};
      if (rr_sum >= (GW+1)'(NSRC)) rr_sum = rr_sum - (GW+1)'(NSRC);
      rr_idx = rr_sum[GW-1:0];
   end

   // Owner FSM and winner selection. Fixed mode never owns, so switching to
   // rrMode=0 drops ownership at the next edge; rr_ptr is left untouched.
   always_comb begin
      state_nxt  = OWN_IDLE;
      rr_ptr_nxt = rr_ptr;
      win_idx    = fixed_idx;
      if (rrMode && any_req) begin
         state_nxt = OWN_OWNED;
         if (state == OWN_OWNED && req_at_ptr) begin
            win_idx = rr_ptr;
         end else begin
            win_idx    = rr_idx;
            rr_ptr_nxt = rr_idx;
         end
      end
   end

   assign win_oh = NSRC'(1) << win_idx;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         sel_data = sel_data | ({WIDTH{win_oh[i]}} & drvData[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         state  <= OWN_IDLE;
         rr_ptr <= LAST_IDX;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         EBUS           <= '0;
         ebusValid      <= 1'b0;
         grantOH        <= '0;
         grantIdx       <= '0;
         conflict       <= 1'b0;
         conflictSticky <= 1'b0;
      end else begin
         ebusValid <= any_req;
         grantOH   <= any_req ? win_oh : '0;
         if (any_req) begin
            EBUS     <= sel_data;
            grantIdx <= win_idx;
         end
         conflict <= multi_req;
         // A conflict in the same cycle as a clear keeps the flag set.
         if (multi_req)        conflictSticky <= 1'b1;
         else if (clrConflict) conflictSticky <= 1'b0;
      end
   end

`ifdef EBUS_CONFLICT_LOG_EN
   logic [15:0]     conf_cnt;
   logic [NSRC-1:0] first_mask;

   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         conf_cnt   <= '0;
         first_mask <= '0;
      end else if (multi_req) begin
         // A same-cycle clear restarts the log with this conflict.
         if (clrConflict)                conf_cnt <= 16'd1;
         else if (conf_cnt != 16'hFFFF)  conf_cnt <= conf_cnt + 16'd1;
         if (clrConflict || !conflictSticky) first_mask <= drvReq;
      end else if (clrConflict) begin
         conf_cnt   <= '0;
         first_mask <= '0;
      end
   end

   assign conflictCount = conf_cnt;
   assign firstConflict = first_mask;
`else
   assign conflictCount = '0;
   assign firstConflict = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ebus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ebus_arbiter                                                 |
// | Purpose  : Self-checking bench for ebus_arbiter (NSRC=8, WIDTH=36). A      |
// |            behavioural model of the arbitration rules predicts every      |
// |            output after each clock edge.                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ebus_arbiter;
   localparam int NSRC  = 8;
   localparam int WIDTH = 36;
   localparam int GW    = 4;
`ifdef EBUS_CONFLICT_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  rr_mode = 1'b0;
   logic                  clr = 1'b0;
   logic [NSRC-1:0]       req = '0;
   logic [NSRC*WIDTH-1:0] data = '0;
   logic [0:WIDTH-1]      ebus;
   logic                  valid;
   logic [NSRC-1:0]       goh;
   logic [GW-1:0]         gidx;
   logic                  conf;
   logic                  sticky;
   logic [15:0]           ccount;
   logic [NSRC-1:0]       fconf;

   always #5 clk = ~clk;

   ebus_arbiter #(.NSRC(NSRC), .WIDTH(WIDTH), .GW(GW)) dut (
      .eboxClk       (clk),
      .eboxResetN    (rst_n),
      .rrMode        (rr_mode),
      .drvReq        (req),
      .drvData       (data),
      .clrConflict   (clr),
      .EBUS          (ebus),
      .ebusValid     (valid),
      .grantOH       (goh),
      .grantIdx      (gidx),
      .conflict      (conf),
      .conflictSticky(sticky),
      .conflictCount (ccount),
      .firstConflict (fconf)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [WIDTH-1:0] m_ebus;
   bit               m_valid;
   logic [NSRC-1:0]  m_oh;
   int               m_idx;
   int               m_ptr;
   bit               m_owned;
   bit               m_conf;
   bit               m_sticky;
   int               m_count;
   logic [NSRC-1:0]  m_first;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ebus = '0; m_valid = 0; m_oh = '0; m_idx = 0; m_ptr = NSRC-1;
      m_owned = 0; m_conf = 0; m_sticky = 0; m_count = 0; m_first = '0;
   endtask

   // Predict the outputs produced by the coming edge from the current inputs.
   task automatic model_edge();
      int n;
      int win;
      n   = $countones(req);
      win = -1;
      if (n > 0) begin
         if (!rr_mode) begin
            for (int i = NSRC-1; i >= 0; i--) if (req[i]) win = i;
         end else if (m_owned && req[m_ptr]) begin
            win = m_ptr;
         end else begin
            for (int k = NSRC; k >= 1; k--) if (req[(m_ptr + k) % NSRC]) win = (m_ptr + k) % NSRC;
            m_ptr = win;
         end
         m_ebus  = data[win*WIDTH +: WIDTH];
         m_valid = 1;
         m_oh    = NSRC'(1) << win;
         m_idx   = win;
      end else begin
         m_valid = 0;
         m_oh    = '0;
      end
      m_owned = rr_mode && (n > 0);
      m_conf  = (n >= 2);
      if (m_conf) begin
         if (clr || !m_sticky) m_first = req;
         m_count  = clr ? 1 : ((m_count < 65535) ? m_count + 1 : 65535);
         m_sticky = 1;
      end else if (clr) begin
         m_sticky = 0;
         m_count  = 0;
         m_first  = '0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ebus"},   64'(ebus),   64'(m_ebus));
      check({tag, ".valid"},  64'(valid),  64'(m_valid));
      check({tag, ".oh"},     64'(goh),    64'(m_oh));
      check({tag, ".idx"},    64'(gidx),   64'(m_idx));
      check({tag, ".conf"},   64'(conf),   64'(m_conf));
      check({tag, ".sticky"}, 64'(sticky), 64'(m_sticky));
      check({tag, ".count"},  64'(ccount), LOG_EN ? 64'(m_count) : 64'd0);
      check({tag, ".first"},  64'(fconf),  LOG_EN ? 64'(m_first) : 64'd0);
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic rand_data();
      for (int i = 0; i < NSRC; i++) data[i*WIDTH +: WIDTH] = WIDTH'({$urandom(), $urandom()});
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      int               exp_g;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Traffic, then asynchronous reset between edges
      for (int i = 0; i < 5; i++) begin
         rand_data(); req = NSRC'($urandom()); rr_mode = 1'($urandom());
         step("pre_rst");
      end
      req = 8'h03;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      rst_n = 1'b1;
      rr_mode = 1'b0;
      req = 8'h01;
      data[0 +: WIDTH] = 36'o123456701234;
      step("first_grant");
      check("first_grant.ebus_const", 64'(ebus), 64'(36'o123456701234));
      check("first_grant.idx_const",  64'(gidx), 64'd0);

      // Fixed priority with conflict, then idle hold
      rand_data(); req = 8'h28;
      step("prio");
      check("prio.idx_const",    64'(gidx),   64'd3);
      check("prio.oh_const",     64'(goh),    64'h08);
      check("prio.conf_const",   64'(conf),   64'd1);
      check("prio.sticky_const", 64'(sticky), 64'd1);
      held = m_ebus;
      rand_data(); req = 8'h00;
      step("idle");
      check("idle.ebus_hold",   64'(ebus),  64'(held));
      check("idle.valid_const", 64'(valid), 64'd0);

      // Round-robin alternation with idle gaps
      rr_mode = 1'b1;
      for (int p = 0; p < 4; p++) begin
         rand_data(); req = 8'h81;
         step("rr");
         exp_g = (p % 2 == 0) ? 0 : 7;
         check("rr.idx_const", 64'(gidx), 64'(exp_g));
         req = 8'h00;
         step("rr_gap");
      end

      // Parking
      for (int p = 0; p < 4; p++) begin
         rand_data(); req = 8'h81;
         step("park");
         check("park.idx_const", 64'(gidx), 64'd0);
      end
      req = 8'h80;
      step("unpark");
      check("unpark.idx_const", 64'(gidx), 64'd7);

      // Sticky versus clear
      clr = 1'b1; req = 8'h03;
      step("clr_conf");
      check("clr_conf.sticky_const", 64'(sticky), 64'd1);
      req = 8'h00;
      step("clr_alone");
      check("clr_alone.sticky_const", 64'(sticky), 64'd0);
      clr = 1'b0;

      // Conflict log
      req = 8'h05; step("log1");
      req = 8'h00; step("log_gap");
      req = 8'h0A; step("log2");
      req = 8'h30; step("log3");
      check("log.count", 64'(ccount), LOG_EN ? 64'd3 : 64'd0);
      check("log.first", 64'(fconf),  LOG_EN ? 64'h05 : 64'd0);
      if (LOG_EN) begin
         req = 8'h03;
         for (int i = 0; i < 70000; i++) begin
            model_edge();
            @(posedge clk);
         end
         #1;
         check_all("sat");
         check("sat.count_const", 64'(ccount), 64'hFFFF);
      end
      req = 8'h00; clr = 1'b1;
      step("log_clr");
      clr = 1'b0;

      // Randomized traffic with mode switches and clears
      for (int i = 0; i < 400; i++) begin
         rand_data();
         case ($urandom_range(3))
            0:       req = '0;
            1:       req = NSRC'(1) << $urandom_range(NSRC-1);
            default: req = NSRC'($urandom());
         endcase
         if ($urandom_range(15) == 0) rr_mode = ~rr_mode;
         clr = ($urandom_range(7) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
